// File: rtl/bus_pkg.sv
// Shared bus types: serial frame layout, decoder error codes and queue entry.
package bus_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 8;
  // Wide enough for the largest legal channel count (8).
  localparam int unsigned CH_IDX_W   = 3;

  typedef enum logic [1:0] {
    CMD_READ        = 2'd0,
    CMD_WRITE       = 2'd1,
    CMD_SPLIT_START = 2'd2,
    CMD_SPLIT_CONT  = 2'd3
  } cmd_e;

  typedef struct packed {
    logic                  start;
    cmd_e                  cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  stop;
  } serial_frame_t;

  typedef enum logic [1:0] {
    DEC_ERR_PARITY  = 2'd0,
    DEC_ERR_START   = 2'd1,
    DEC_ERR_STOP    = 2'd2,
    DEC_ERR_OVERRUN = 2'd3
  } dec_err_e;

  typedef struct packed {
    logic [CH_IDX_W-1:0]   ch;
    cmd_e                  cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } dec_entry_t;

  // Commands that carry write data.
  function automatic logic is_write(cmd_e cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_SPLIT_START);
  endfunction

endpackage

// File: rtl/decoder_fifo.sv
// Synchronous FIFO of decoded entries with wrap-around pointers.
module decoder_fifo
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  dec_entry_t wdata_i,
  input  logic       pop_i,
  output dec_entry_t rdata_o,
  output logic [AW:0] count_o,
  output logic       full_o,
  output logic       empty_o
);

  dec_entry_t        mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       cnt_q;
  logic              push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is legal only alongside a pop.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointer and occupancy update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/frame_decoder_mc.sv
// Multi-channel frame decoder: per-channel check and hold, round-robin merge
// into a queue, per-channel error pulses and saturating statistics.
module frame_decoder_mc
  import bus_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic          [NUM_CH-1:0]    frame_valid_i,
  input  serial_frame_t [NUM_CH-1:0]    frame_i,
  input  logic          [NUM_CH-1:0]    parity_err_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic          [CH_W-1:0]      ch_o,
  output cmd_e                          cmd_o,
  output logic          [ADDR_WIDTH-1:0] addr_o,
  output logic          [DATA_WIDTH-1:0] wdata_o,
  output logic                          we_o,
  output logic          [NUM_CH-1:0]    err_o,
  output dec_err_e      [NUM_CH-1:0]    err_code_o,
  input  logic                          clr_cnt_i,
  output logic          [CNT_WIDTH-1:0] frame_cnt_o,
  output logic          [CNT_WIDTH-1:0] err_cnt_o
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned SumW = CNT_WIDTH + 4;

  typedef enum logic {StEmpty, StFull} hold_st_e;

  hold_st_e   [NUM_CH-1:0] hold_st_q;
  dec_entry_t [NUM_CH-1:0] hold_q;
  dec_entry_t [NUM_CH-1:0] new_entry;
  logic       [NUM_CH-1:0] good, err_d, err_q, gnt_vec;
  dec_err_e   [NUM_CH-1:0] code_d, code_q;
  logic       [CH_W-1:0]   rr_q, gnt_idx;
  logic                    gnt_valid, can_push, pop;
  int unsigned             idx;
  dec_entry_t              fifo_rdata, head;
  logic       [AW:0]       fifo_cnt;
  logic                    fifo_full, fifo_empty;
  logic [CNT_WIDTH-1:0]    frame_cnt_q, err_cnt_q, err_cnt_d;
  logic [SumW-1:0]         err_sum;
  logic                    unused_bits;

  assign pop      = valid_o && ready_i;
  assign can_push = !fifo_full || pop;

  // Round-robin grant starting at rr_q; only when the queue can take it.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_vec   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_q) + i) % NUM_CH;
      if (!gnt_valid && can_push && hold_st_q[idx] == StFull) begin
        gnt_valid    = 1'b1;
        gnt_idx      = CH_W'(idx);
        gnt_vec[idx] = 1'b1;
      end
    end
  end

  // Per-channel validation; overrun pre-empts the frame checks.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      good[c]      = 1'b0;
      err_d[c]     = 1'b0;
      code_d[c]    = DEC_ERR_PARITY;
      new_entry[c] = '{ch: CH_IDX_W'(c), cmd: frame_i[c].cmd,
                       addr: frame_i[c].addr, data: frame_i[c].data};
      if (frame_valid_i[c]) begin
        err_d[c] = 1'b1;
        if (hold_st_q[c] == StFull && !gnt_vec[c]) code_d[c] = DEC_ERR_OVERRUN;
        else if (parity_err_i[c])                  code_d[c] = DEC_ERR_PARITY;
        else if (!frame_i[c].start)                code_d[c] = DEC_ERR_START;
        else if (!frame_i[c].stop)                 code_d[c] = DEC_ERR_STOP;
        else begin
          err_d[c] = 1'b0;
          good[c]  = 1'b1;
        end
      end
    end
  end

  // Hold register FSM per channel; a new frame wins over a same-cycle grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NUM_CH; c++) hold_st_q[c] <= StEmpty;
      hold_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (good[c]) begin
          hold_st_q[c] <= StFull;
          hold_q[c]    <= new_entry[c];
        end else if (gnt_vec[c]) begin
          hold_st_q[c] <= StEmpty;
        end
      end
    end
  end

  // Round-robin pointer moves past the granted channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        rr_q <= '0;
    else if (gnt_valid) rr_q <= (32'(gnt_idx) + 1 == NUM_CH) ? '0 : gnt_idx + 1'b1;
  end

  // Registered error pulses and codes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q  <= '0;
      code_q <= '0;
    end else begin
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  // Saturating error accumulation.
  always_comb begin
    err_sum = SumW'(err_cnt_q) + SumW'($countones(err_d));
    if (err_sum > SumW'({CNT_WIDTH{1'b1}})) err_cnt_d = '1;
    else                                   err_cnt_d = CNT_WIDTH'(err_sum);
  end

  // Statistics counters; clear overrides increments.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (clr_cnt_i) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (gnt_valid && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 1'b1;
      err_cnt_q <= err_cnt_d;
    end
  end

  decoder_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_valid),
    .wdata_i (hold_q[gnt_idx]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head fields read as zero whenever the queue is empty.
  always_comb begin
    head = fifo_empty ? '0 : fifo_rdata;
  end

  assign valid_o     = !fifo_empty;
  assign ch_o        = CH_W'(head.ch);
  assign cmd_o       = head.cmd;
  assign addr_o      = head.addr;
  assign wdata_o     = head.data;
  assign we_o        = is_write(head.cmd);
  assign err_o       = err_q;
  assign err_code_o  = code_q;
  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign unused_bits = ^{fifo_cnt, head.ch};

endmodule

// File: tb/tb_frame_decoder_mc.sv
// Directed bench for frame_decoder_mc with an output scoreboard.
module tb_frame_decoder_mc;
  import bus_pkg::*;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CH_W   = 1;
  localparam int unsigned CNT_W  = 8;
  localparam int          CNT_MAX = 255;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic          [NUM_CH-1:0]  frame_valid_i;
  serial_frame_t [NUM_CH-1:0]  frame_i;
  logic          [NUM_CH-1:0]  parity_err_i;
  logic                        valid_o, ready_i, we_o, clr_cnt_i;
  logic          [CH_W-1:0]    ch_o;
  cmd_e                        cmd_o;
  logic [ADDR_WIDTH-1:0]       addr_o;
  logic [DATA_WIDTH-1:0]       wdata_o;
  logic          [NUM_CH-1:0]  err_o;
  dec_err_e      [NUM_CH-1:0]  err_code_o;
  logic [CNT_W-1:0]            frame_cnt_o, err_cnt_o;

  int         n_pass = 0;
  int         n_total = 0;
  int         exp_frames = 0;
  dec_entry_t sb[$];

  frame_decoder_mc #(
    .NUM_CH     (NUM_CH),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .frame_valid_i (frame_valid_i),
    .frame_i       (frame_i),
    .parity_err_i  (parity_err_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .ch_o          (ch_o),
    .cmd_o         (cmd_o),
    .addr_o        (addr_o),
    .wdata_o       (wdata_o),
    .we_o          (we_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o),
    .clr_cnt_i     (clr_cnt_i),
    .frame_cnt_o   (frame_cnt_o),
    .err_cnt_o     (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    frame_valid_i = '0;
    parity_err_i  = '0;
  endtask

  // Drive one frame on a channel; a frame expected to pass is queued in order.
  task automatic drive(int ch, cmd_e cmd, logic [15:0] addr, logic [7:0] data,
                       logic par, logic st, logic sp, bit ok);
    dec_entry_t e;
    frame_valid_i[ch] = 1'b1;
    parity_err_i[ch]  = par;
    frame_i[ch]       = '{start: st, cmd: cmd, addr: addr, data: data, stop: sp};
    if (ok) begin
      e = '{ch: 3'(ch), cmd: cmd, addr: addr, data: data};
      sb.push_back(e);
      exp_frames++;
    end
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) cyc();
    chk(tag, 32'(sb.size()), 0);
  endtask

  function automatic int sat(int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Scoreboard: every accepted head must match the oldest expectation.
  always @(negedge clk_i) begin
    dec_entry_t e;
    logic       exp_we;
    if (rst_ni && valid_o && ready_i) begin
      chk("sb_unexpected_pop", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e      = sb.pop_front();
        exp_we = (e.cmd == CMD_WRITE) || (e.cmd == CMD_SPLIT_START);
        chk("head_ch", 32'(ch_o), 32'(e.ch));
        chk("head_cmd", 32'(cmd_o), 32'(e.cmd));
        chk("head_addr", 32'(addr_o), 32'(e.addr));
        chk("head_wdata", 32'(wdata_o), 32'(e.data));
        chk("head_we", 32'(we_o), 32'(exp_we));
      end
    end
  end

  initial begin
    rst_ni = 1'b0; ready_i = 1'b0; clr_cnt_i = 1'b0; frame_i = '0;
    idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_ch", 32'(ch_o), 0);
    chk("rst_cmd", 32'(cmd_o), 0);
    chk("rst_addr", 32'(addr_o), 0);
    chk("rst_wdata", 32'(wdata_o), 0);
    chk("rst_we", 32'(we_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_err_code", 32'(err_code_o), 0);
    chk("rst_frame_cnt", 32'(frame_cnt_o), 0);
    chk("rst_err_cnt", 32'(err_cnt_o), 0);
    cyc();
    rst_ni = 1'b1;

    // Single good frame and its latency.
    ready_i = 1'b1;
    drive(0, CMD_WRITE, 16'h1234, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(); idle();
    @(negedge clk_i);
    chk("lat_n1_valid", 32'(valid_o), 0);
    chk("good_no_err", 32'(err_o), 0);
    cyc();
    @(negedge clk_i);
    chk("lat_n2_valid", 32'(valid_o), 1);
    chk("frame_cnt_1", 32'(frame_cnt_o), 1);
    drain("single_drain");

    // Error classes on ch1: parity, start, stop.
    drive(1, CMD_WRITE, 16'h0, 8'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(); idle();
    drive(1, CMD_WRITE, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("err_par_pulse", 32'(err_o), 32'b10);
    chk("err_par_code", 32'(err_code_o[1]), 32'(DEC_ERR_PARITY));
    cyc(); idle();
    drive(1, CMD_WRITE, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("err_start_pulse", 32'(err_o), 32'b10);
    chk("err_start_code", 32'(err_code_o[1]), 32'(DEC_ERR_START));
    cyc(); idle();
    @(negedge clk_i);
    chk("err_stop_pulse", 32'(err_o), 32'b10);
    chk("err_stop_code", 32'(err_code_o[1]), 32'(DEC_ERR_STOP));
    chk("err_cnt_3", 32'(err_cnt_o), 3);
    cyc();
    @(negedge clk_i);
    chk("err_pulse_end", 32'(err_o), 0);
    chk("err_none_queued", 32'(valid_o), 0);
    chk("err_frame_cnt", 32'(frame_cnt_o), 1);

    // Pointer is at ch1 after the first grant; a lone ch1 frame moves it to ch0.
    drive(1, CMD_READ, 16'h0BEE, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(); idle();
    drain("lone1_drain");
    drive(0, CMD_READ, 16'h0001, 8'h21, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(1, CMD_WRITE, 16'h0002, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(); idle();
    drain("pair1_drain");
    // Lone ch0 grant leaves the pointer on ch1, so the next pair leads with ch1.
    drive(0, CMD_SPLIT_CONT, 16'h0003, 8'h23, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(); idle();
    drain("lone0_drain");
    drive(1, CMD_SPLIT_START, 16'h0012, 8'h32, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(0, CMD_WRITE, 16'h0011, 8'h31, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(); idle();
    drain("pair2_drain");

    // Full queue plus hold register, then overrun on the sixth frame.
    ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(0, CMD_WRITE, 16'(16'h0100 + i), 8'(i), 1'b0, 1'b1, 1'b1, i < 5);
      cyc();
    end
    idle();
    @(negedge clk_i);
    chk("ovr_pulse", 32'(err_o), 32'b01);
    chk("ovr_code", 32'(err_code_o[0]), 32'(DEC_ERR_OVERRUN));
    chk("ovr_err_cnt", 32'(err_cnt_o), 4);
    chk("full_head", 32'(addr_o), 32'h0100);
    cyc(); cyc();
    @(negedge clk_i);
    chk("stall_valid", 32'(valid_o), 1);
    chk("stall_head_stable", 32'(addr_o), 32'h0100);
    chk("stall_frame_cnt", 32'(frame_cnt_o), 32'(sat(exp_frames - 1)));
    cyc();
    ready_i = 1'b1;
    drain("ovr_drain");
    @(negedge clk_i);
    chk("ovr_frame_cnt", 32'(frame_cnt_o), 32'(sat(exp_frames)));

    // Sustained back-to-back frames drive the frame counter into saturation.
    for (int i = 0; i < 260; i++) begin
      drive(0, CMD_SPLIT_START, 16'(16'h2000 + i), 8'(i), 1'b0, 1'b1, 1'b1, 1'b1);
      cyc();
    end
    idle();
    drain("sat_drain");
    @(negedge clk_i);
    chk("sat_frame_cnt", 32'(frame_cnt_o), 32'(sat(exp_frames)));
    chk("sustained_no_err", 32'(err_cnt_o), 4);

    // Clear coinciding with a push.
    drive(1, CMD_READ, 16'h3000, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(); idle();
    clr_cnt_i = 1'b1;
    cyc();
    clr_cnt_i = 1'b0;
    exp_frames = 0;
    @(negedge clk_i);
    chk("clr_frame_cnt", 32'(frame_cnt_o), 0);
    chk("clr_err_cnt", 32'(err_cnt_o), 0);
    drive(0, CMD_WRITE, 16'h3001, 8'h78, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(); idle();
    cyc();
    @(negedge clk_i);
    chk("post_clr_frame_cnt", 32'(frame_cnt_o), 32'(sat(exp_frames)));
    drain("clr_drain");

    // Reset with three entries queued.
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, CMD_WRITE, 16'(16'h4000 + i), 8'(i), 1'b0, 1'b1, 1'b1, 1'b1);
      cyc();
    end
    idle();
    cyc(); cyc(); cyc();
    @(negedge clk_i);
    chk("pre_rst_valid", 32'(valid_o), 1);
    cyc();
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_addr", 32'(addr_o), 0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt_o), 0);
    sb.delete();
    exp_frames = 0;
    cyc(); cyc();
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    repeat (8) cyc();
    @(negedge clk_i);
    chk("post_rst_no_stale", 32'(valid_o), 0);
    drive(1, CMD_WRITE, 16'h0777, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(); idle();
    drain("post_rst_drain");
    @(negedge clk_i);
    chk("post_rst_frame_cnt", 32'(frame_cnt_o), 32'(sat(exp_frames)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frame_decoder_mc.md
# frame_decoder_mc

Multi-channel, buffered frame decoder sitting between `NUM_CH` serial deserialisers and the bus slave-side command interface. Each cycle it validates every arriving `serial_frame_t`, classifies errors per channel and round-robin merges good frames into a `FIFO_DEPTH`-entry queue. The queue drains through a ready/valid handshake. The block also keeps saturating frame and error statistics.

## Interface
Parameters:
- `NUM_CH`, 2: number of input channels; legal range 1..8.
- `FIFO_DEPTH`, 4: output queue entries; power of two, minimum 2.
- `CNT_WIDTH`, 8: statistics counter width.
- `CH_W`, `(NUM_CH>1)?$clog2(NUM_CH):1`: derived channel index width.

Ports (all inputs sampled and all outputs driven on `clk_i`):
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `frame_valid_i` in `[NUM_CH]`: one-cycle frame strobe per channel.
- `frame_i` in `serial_frame_t [NUM_CH]`: frame per channel.
- `parity_err_i` in `[NUM_CH]`: parity flag, qualified by `frame_valid_i`.
- `valid_o` out 1: queue head valid.
- `ready_i` in 1: consumer accepts the head.
- `ch_o` out `CH_W`: source channel of the head.
- `cmd_o` out, width of `serial_frame_t.cmd`: command of the head.
- `addr_o` out `ADDR_WIDTH`: address of the head.
- `wdata_o` out `DATA_WIDTH`: write data of the head.
- `we_o` out 1: 1 iff head cmd is `CMD_WRITE` or `CMD_SPLIT_START`.
- `err_o` out `[NUM_CH]`: one-cycle error pulse per channel.
- `err_code_o` out `dec_err_e [NUM_CH]`: cause, valid while the matching `err_o` bit is high.
- `clr_cnt_i` in 1: synchronous clear of both counters.
- `frame_cnt_o` out `CNT_WIDTH`: frames enqueued, saturating.
- `err_cnt_o` out `CNT_WIDTH`: error events, saturating.

## Operation
- **Per-channel check.** Runs when `frame_valid_i[c]=1`.
  - If the channel hold register is occupied and is not being granted this cycle, the result is `DEC_ERR_OVERRUN`. The new frame is dropped without further checks.
  - Otherwise the checks run in priority order: parity (`DEC_ERR_PARITY`), then `start!=1` (`DEC_ERR_START`), then `stop!=1` (`DEC_ERR_STOP`). A frame that fails is dropped.
  - A frame that passes is written to the hold register: ch, cmd, addr, data.
- **Hold/arbiter state per channel.** Two states: `EMPTY` and `FULL`.
  - `EMPTY` -> `FULL` on a good frame.
  - `FULL` -> `EMPTY` on grant.
  - Grant plus a good frame in the same cycle stays `FULL` and takes the new contents.
- **Arbiter rules.**
  - At most one grant per cycle.
  - A grant is issued only if the FIFO can accept: `count<FIFO_DEPTH`, or a pop happens in the same cycle.
  - Priority is round-robin. The pointer starts at channel 0 after reset and moves to granted+1 mod `NUM_CH`.
- **FIFO.**
  - Push on grant; pop on `valid_o && ready_i`.
  - Push and pop together leave the count unchanged, including when the FIFO is full.
  - Head outputs are held stable while `valid_o=1` and `ready_i=0`.
- **Counters.**
  - `frame_cnt_o` adds 1 per push.
  - `err_cnt_o` adds popcount(errors detected this cycle).
  - Both saturate at all-ones and never wrap.
  - `clr_cnt_i` wins over any same-cycle increment; both counters read 0 the next cycle.

## Timing
- **Reset values.** All outputs reset to 0: `valid_o`, `ch_o`, `cmd_o`, `addr_o`, `wdata_o`, `we_o`, `err_o`, `err_code_o` (`DEC_ERR_PARITY`=0), and both counters.
  - Hold registers go to `EMPTY`; FIFO goes empty; arbiter pointer goes to 0.
- **Reset mid-operation** discards every held and queued frame immediately. No partial output appears after release.
- **Error latency.** `err_o[c]` and `err_code_o[c]` are registered and pulse exactly 1 cycle after the offending `frame_valid_i[c]`. There is no pulse for good frames.
- **Frame latency.** A good frame strobed at edge N is held at N+1, granted and pushed at N+2, so `valid_o=1` from N+2.
  - This assumes its channel is granted first and the FIFO has space.
  - There is no bypass path.
- **Sustained rate.** One push per cycle. Consecutive strobes on one channel with free FIFO space never overrun.
- **Frame strobes ignore `ready_i`.** Backpressure appears only as overrun errors.

## Structure
- Add to `bus_pkg`:
  - `dec_err_e` (2 bits): `DEC_ERR_PARITY`=0, `DEC_ERR_START`=1, `DEC_ERR_STOP`=2, `DEC_ERR_OVERRUN`=3.
  - `dec_entry_t` struct: ch, cmd, addr, data.
- Sub-module `decoder_fifo`: a generic synchronous FIFO of `dec_entry_t`, parameter `DEPTH`, with wrap-around read/write pointers and `count`, `full` and `empty` flags.
- Hold registers, arbiter, error logic and counters live in `frame_decoder_mc`.

## Test plan
- **Single good frame.** `NUM_CH=2`, ch0 frame with cmd `CMD_WRITE`, addr 0x1234, data 0xA5, `ready_i=1`. Expect `valid_o` 2 cycles later with ch 0, addr 0x1234, wdata 0xA5, we 1, and `frame_cnt_o`=1.
- **Error classes.** On ch1, send a parity error, then start=0, then stop=0. Expect `err_o[1]` pulses 1 cycle later with codes 0, 1, 2. Expect `err_cnt_o`=3 and nothing enqueued.
- **Simultaneous arrival.** ch0 (addr 0x0001) and ch1 (addr 0x0002) in the same cycle. Expect pops in order 0x0001 then 0x0002. A second simultaneous pair then pops ch1 first, per the round-robin pointer.
- **Full FIFO and overrun.** `ready_i=0`, 5 frames on ch0 with `FIFO_DEPTH=4`.
  - FIFO fills with 4 frames; the 5th sits in the hold register.
  - A 6th frame gives `DEC_ERR_OVERRUN`.
  - Raise `ready_i`: exactly 5 frames drain, in order.
- **Counter saturation and clear.** `CNT_WIDTH=2`, 5 good frames. Expect `frame_cnt_o` sticks at 3. `clr_cnt_i` on the same cycle as a push gives 0.
- **Reset mid-operation.** Assert `rst_ni` low with 3 entries queued. Expect `valid_o`=0 immediately. After release, no stale frames are output.
